// File: rtl/reg_file.sv
// MIPS general-purpose register file: two combinational read ports (rs/rt),
// one clocked write port, r0 hardwired to zero, write-to-read bypass so a
// same-cycle writeback is visible to decode.
module reg_file #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [WIDTH-1:0]      rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [WIDTH-1:0]      rdata2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] regs [DEPTH];

  // A write is committed only outside reset and never to r0.
  logic write_ok;
  assign write_ok = we && (waddr != '0);

  // Storage: async active-low clear of every register, clocked writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
    end else if (write_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1 (rs): reset > r0 > bypass > stored value.
  always_comb begin
    rdata1 = '0;
    if (!rst || raddr1 == '0) begin
      rdata1 = '0;
    end else if (write_ok && waddr == raddr1) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  // Read port 2 (rt): same priority as port 1, fully independent.
  always_comb begin
    rdata2 = '0;
    if (!rst || raddr2 == '0) begin
      rdata2 = '0;
    end else if (write_ok && waddr == raddr2) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time bound so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Drive one write, set up at the falling edge, committed at the next rising edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    // Reads are zero while held in reset, even with a matching bypass.
    @(negedge clk);
    we = 1'b1; waddr = 5'd6; wdata = 32'hCAFEF00D; raddr1 = 5'd6; raddr2 = 5'd0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_no_bypass: rdata1=%h expected %h", rdata1, 32'h0);
    end
    // Reset held across a we=1 edge: the write must be dropped.
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wins_write: rdata1=%h expected %h", rdata1, 32'h0);
    end
    // Store r5, then pulse reset between edges.
    do_write(5'd5, 32'hA5A5A5A5);
    raddr1 = 5'd5;
    #1;
    n_checks++;
    if (rdata1 !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL reset_prewrite: rdata1=%h expected %h", rdata1, 32'hA5A5A5A5);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async_read: rdata1=%h expected %h", rdata1, 32'h0);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cleared: rdata1=%h expected %h", rdata1, 32'h0);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd7, 32'h12345678);
    @(negedge clk);
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    n_checks++;
    if (rdata1 !== 32'h12345678 || rdata2 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL write_read: rdata1=%h rdata2=%h expected %h", rdata1, rdata2, 32'h12345678);
    end
    for (int i = 0; i < 32; i++) begin
      if (i != 7) begin
        raddr1 = 5'(i); raddr2 = 5'(31 - i);
        #1;
        n_checks++;
        if (rdata1 !== 32'h0 || (i != 24 && rdata2 !== 32'h0)) begin
          n_fail++;
          $display("FAIL others_zero: addr=%0d rdata1=%h rdata2=%h expected 0", i, rdata1, rdata2);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_bypass: rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_after_edge_we: rdata1=%h expected 0", rdata1);
    end
    we = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_after_edge: rdata1=%h expected 0", rdata1);
    end
  endtask

  task automatic test_bypass();
    do_write(5'd3, 32'h11111111);
    do_write(5'd4, 32'h44444444);
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'h22222222; raddr1 = 5'd3; raddr2 = 5'd4;
    #1;
    n_checks++;
    if (rdata1 !== 32'h22222222 || rdata2 !== 32'h44444444) begin
      n_fail++;
      $display("FAIL bypass_pre_edge: rdata1=%h rdata2=%h expected %h %h",
               rdata1, rdata2, 32'h22222222, 32'h44444444);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h22222222) begin
      n_fail++;
      $display("FAIL bypass_committed: rdata1=%h expected %h", rdata1, 32'h22222222);
    end
    // Both ports bypass at once; stored r4 is not yet overwritten.
    @(negedge clk);
    we = 1'b1; waddr = 5'd4; wdata = 32'h55555555; raddr1 = 5'd4; raddr2 = 5'd4;
    #1;
    n_checks++;
    if (rdata1 !== 32'h55555555 || rdata2 !== 32'h55555555) begin
      n_fail++;
      $display("FAIL bypass_dual: rdata1=%h rdata2=%h expected %h", rdata1, rdata2, 32'h55555555);
    end
    we = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h44444444) begin
      n_fail++;
      $display("FAIL bypass_drop_we: rdata1=%h expected %h", rdata1, 32'h44444444);
    end
  endtask

  task automatic test_we_hold();
    @(negedge clk);
    we = 1'b0; waddr = 5'd9; wdata = 32'hDEADBEEF; raddr1 = 5'd9; raddr2 = 5'd9;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        n_fail++;
        $display("FAIL we_hold: cycle=%0d rdata1=%h rdata2=%h expected 0", c, rdata1, rdata2);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] e1, e2;
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'(i) * 32'h01010101);
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      e1 = 32'(i) * 32'h01010101;
      e2 = 32'(31 - i) * 32'h01010101;
      #1;
      n_checks++;
      if (rdata1 !== e1 || rdata2 !== e2) begin
        n_fail++;
        $display("FAIL sweep: pair=(%0d,%0d) rdata1=%h rdata2=%h expected %h %h",
                 i, 31 - i, rdata1, rdata2, e1, e2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    #1;
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_we_hold();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- MIPS general-purpose register file: 2^ADDR_WIDTH words of WIDTH bits.
- Two combinational read ports (rs, rt) feed the decode stage; one clocked write port is driven by writeback.
- Register 0 is hardwired to zero.
- Internal write-to-read bypass, so a same-cycle writeback is visible to decode without external forwarding.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers (32 by default).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; clears every register.
- we  input  1  write enable, sampled on rising clk.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  WIDTH  write data.
- raddr1  input  ADDR_WIDTH  read port 1 address (rs).
- rdata1  output  WIDTH  read port 1 data.
- raddr2  input  ADDR_WIDTH  read port 2 address (rt).
- rdata2  output  WIDTH  read port 2 data.

Behaviour:
- Storage: DEPTH x WIDTH flops, index 0..DEPTH-1.
- Reset: rst=0 asynchronously forces all registers to 0, independent of clk.
  - While rst=0, rdata1 = rdata2 = 0 for every address; the bypass is disabled.
  - Writes are ignored while rst=0.
  - Reset asserted mid-write (same cycle as a we=1 edge): reset wins and the register stays 0.
- Write: on rising clk with rst=1, we=1 and waddr!=0, reg[waddr] <= wdata.
  - we=0: no register changes.
  - waddr=0: write discarded; reg[0] remains 0 permanently.
- Read: purely combinational, zero cycle latency.
  - rdataN = 0 when raddrN=0, regardless of stored value, we or waddr.
  - Bypass: when we=1, waddr=raddrN and raddrN!=0, rdataN = wdata in the same cycle, before the edge commits it (write-before-read semantics).
  - Otherwise rdataN = reg[raddrN].
- Both read ports are independent.
  - raddr1=raddr2 yields identical data.
  - Both ports may bypass simultaneously.
- Priority per read port: rst low > raddr=0 > bypass > stored value.
- No X propagation: every output is defined from reset onward.
- No internal state machine beyond storage. Sequential behaviour is limited to clocked writes plus async clear.

Test Plan:
1. Reset: write 0xA5A5A5A5 to r5, then pulse rst=0 for 3 ns between clock edges -> rdata1 (raddr1=5) reads 0 immediately, before any edge, and after release.
2. Write/read: we=1, waddr=7, wdata=0x12345678 for one cycle, then we=0 -> next cycle raddr1=7 and raddr2=7 both return 0x12345678; all other registers read 0.
3. Zero register: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1 (raddr1=0) = 0 during and after the edge. The bypass must not leak 0xFFFFFFFF.
4. Bypass:
   - Setup: r3=0x11111111 stored. Then we=1, waddr=3, wdata=0x22222222, raddr1=3, raddr2=4.
   - Before the edge: rdata1=0x22222222 and rdata2=reg[4].
   - After the edge with we=0: rdata1=0x22222222.
5. we=0 hold: waddr=9, wdata=0xDEADBEEF, we=0 for 4 cycles -> r9 stays 0; rdata never shows 0xDEADBEEF.
6. Sweep: write r(i)=i*0x01010101 for i=1..31, then read all pairs (i, 31-i) on both ports -> every value matches, and r0 reads 0.
